// File: rtl/or1k_tlb_reload_arbiter.sv
// Arbitrates one memory-read port between the IMMU and DMMU TLB reload engines.
// Grants are held for a whole page-table walk; aborted accesses are drained and hung ones time out.
module or1k_tlb_reload_arbiter #(
  parameter int    OPTION_OPERAND_WIDTH  = 32,
  parameter string FEATURE_ROUND_ROBIN   = "ENABLED",
  parameter int    OPTION_TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            dmmu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
  output logic                            dmmu_ack_o,
  output logic                            dmmu_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,
  input  logic                            immu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
  output logic                            immu_ack_o,
  output logic                            immu_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,
  output logic                            bus_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] bus_addr_o,
  input  logic                            bus_ack_i,
  input  logic                            bus_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] bus_data_i,
  output logic                            owner_o,
  output logic                            busy_o,
  output logic                            timeout_o
);

  localparam bit         ROUND_ROBIN = (FEATURE_ROUND_ROBIN == "ENABLED");
  localparam bit         TMO_EN      = (OPTION_TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TMO_LAST    = 8'(OPTION_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DRAIN} state_t;

  state_t                          state, state_next;
  logic                            owner_next;
  logic                            last_owner, last_owner_next;
  logic [7:0]                      tmo_cnt;
  logic [OPTION_OPERAND_WIDTH-1:0] drain_addr;
  logic                            owner_req;
  logic [OPTION_OPERAND_WIDTH-1:0] owner_addr;
  logic                            winner;
  logic                            tmo_hit;
  logic                            resp_ack, resp_err;

  assign owner_req  = owner_o ? immu_req_i  : dmmu_req_i;
  assign owner_addr = owner_o ? immu_addr_i : dmmu_addr_i;
  assign tmo_hit    = TMO_EN && (tmo_cnt == TMO_LAST);

  // On a tie, round-robin favours whoever did not own the bus last; otherwise DMMU wins.
  always_comb begin
    winner = immu_req_i;
    if (dmmu_req_i && immu_req_i)
      winner = ROUND_ROBIN ? ~last_owner : 1'b0;
  end

  always_comb begin
    state_next      = state;
    owner_next      = owner_o;
    last_owner_next = last_owner;
    bus_req_o       = 1'b0;
    bus_addr_o      = '0;
    resp_ack        = 1'b0;
    resp_err        = 1'b0;
    timeout_o       = 1'b0;
    case (state)
      IDLE: begin
        if (dmmu_req_i || immu_req_i) begin
          owner_next = winner;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        bus_req_o  = 1'b1;
        bus_addr_o = owner_addr;
        if (bus_ack_i) begin
          resp_ack   = 1'b1;
          state_next = GAP;
        end else if (bus_err_i) begin
          resp_err   = 1'b1;
          state_next = GAP;
        end else if (!owner_req) begin
          state_next = DRAIN;
        end else if (tmo_hit) begin
          timeout_o  = 1'b1;
          resp_err   = 1'b1;
          state_next = GAP;
        end
      end
      DRAIN: begin
        // The requester has gone away, so the response is swallowed silently.
        bus_req_o  = 1'b1;
        bus_addr_o = drain_addr;
        if (bus_ack_i || bus_err_i) begin
          state_next = GAP;
        end else if (tmo_hit) begin
          timeout_o  = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        if (owner_req) begin
          state_next = ISSUE;
        end else begin
          last_owner_next = owner_o;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_o    <= 1'b0;
      last_owner <= 1'b1;
      tmo_cnt    <= '0;
      drain_addr <= '0;
    end else begin
      state      <= state_next;
      owner_o    <= owner_next;
      last_owner <= last_owner_next;
      if ((state_next != state) || !((state == ISSUE) || (state == DRAIN)))
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 8'd1;
      if (state == ISSUE)
        drain_addr <= owner_addr;
    end
  end

  assign busy_o      = (state != IDLE);
  assign dmmu_ack_o  = resp_ack && !owner_o;
  assign dmmu_err_o  = resp_err && !owner_o;
  assign immu_ack_o  = resp_ack &&  owner_o;
  assign immu_err_o  = resp_err &&  owner_o;
  assign dmmu_data_o = ((state == ISSUE) && !owner_o) ? bus_data_i : '0;
  assign immu_data_o = ((state == ISSUE) &&  owner_o) ? bus_data_i : '0;

endmodule
